data_memory_responder: RTL and testbench

//   Memory-side responder for the multicore memory controller. Accepts the single

---
 rtl/data_memory_responder.sv | 147 ++++++++++++++
 tb/tb_data_memory_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//   Memory-side responder for the multicore memory controller. Holds DEPTH
//   lines of DATA_W bits (four packed 16-bit core words per line), clears the
//   whole array after reset, then serves one shared request stream with a
//   pipelined read path of fixed latency (RD_LAT = 1 or 2).
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   asynchronous active-high reset
//   memWR        in   write request
//   MemREAD      in   read request
//   memAddr      in   16-bit line address, index = memAddr[ADDR_W-1:0]
//   datatoMem    in   write data
//   datafromMem  out  read data, holds between reads
//   rdValid      out  one-cycle pulse when datafromMem updates
//   ready        out  array initialised, requests accepted
//   addrErr      out  sticky out-of-range flag, cleared only by rst
// ---------------------------------------------------------------------------
module data_memory_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memWR,
  input  logic              MemREAD,
  input  logic [15:0]       memAddr,
  input  logic [DATA_W-1:0] datatoMem,
  output logic [DATA_W-1:0] datafromMem,
  output logic              rdValid,
  output logic              ready,
  output logic              addrErr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_initCnt;
  logic              r_ready;
  logic              r_addrErr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;

  logic [ADDR_W-1:0] w_idx;
  logic              w_upperSet;
  logic              w_wrAcc;
  logic              w_rdAcc;

  assign w_idx      = memAddr[ADDR_W-1:0];
  assign w_upperSet = (memAddr >> ADDR_W) != 16'd0;
  // Requests only count once the array is clean; r_ready mirrors ST_RUN.
  assign w_wrAcc    = r_ready & memWR;
  assign w_rdAcc    = r_ready & MemREAD;

  // Init/run sequencing. INIT walks initCnt over every line, and the edge that
  // clears the last line (all ones) is the same edge that raises ready, so
  // INIT lasts exactly DEPTH cycles and initCnt never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_initCnt <= '0;
      r_ready   <= 1'b0;
      r_addrErr <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (&r_initCnt) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_initCnt <= r_initCnt + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if ((w_wrAcc | w_rdAcc) & w_upperSet) begin
            r_addrErr <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Array storage has no reset; the INIT sweep clears it instead. While rst is
  // held this keeps rewriting line 0 with zero, which the sweep would do anyway.
  always_ff @(posedge clk) begin
    if (!r_ready) begin
      r_mem[r_initCnt] <= '0;
    end else if (memWR) begin
      r_mem[w_idx] <= datatoMem;
    end
  end

  // First read stage. The array is read with the pre-edge contents, so a
  // same-cycle write to the same line returns the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_rdAcc;
      if (w_rdAcc) begin
        r_rdData <= r_mem[w_idx];
      end
    end
  end

  // Optional second stage for RD_LAT=2; any other value behaves as RD_LAT=1.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_outData;
      logic              r_outValid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_outData  <= '0;
          r_outValid <= 1'b0;
        end else begin
          r_outValid <= r_rdValid;
          if (r_rdValid) begin
            r_outData <= r_rdData;
          end
        end
      end

      assign datafromMem = r_outData;
      assign rdValid     = r_outValid;
    end else begin : g_lat1
      assign datafromMem = r_rdData;
      assign rdValid     = r_rdValid;
    end
  endgenerate

  assign ready   = r_ready;
  assign addrErr = r_addrErr;

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//   Drives one request stream into two responders (RD_LAT=1 and RD_LAT=2) and
//   checks both against a behavioural model of the memory every cycle, with
//   directed scenarios plus randomized traffic and a few literal expectations.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memWR = 1'b0;
  logic        MemREAD = 1'b0;
  logic [15:0] memAddr = '0;
  logic [63:0] datatoMem = '0;

  logic [63:0] data1, data2;
  logic        valid1, valid2, ready1, ready2, addrErr1, addrErr2;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_W(ADDR_W), .DATA_W(64), .RD_LAT(1)) dutLat1 (
    .clk(clk), .rst(rst), .memWR(memWR), .MemREAD(MemREAD), .memAddr(memAddr),
    .datatoMem(datatoMem), .datafromMem(data1), .rdValid(valid1), .ready(ready1),
    .addrErr(addrErr1)
  );

  data_memory_responder #(.ADDR_W(ADDR_W), .DATA_W(64), .RD_LAT(2)) dutLat2 (
    .clk(clk), .rst(rst), .memWR(memWR), .MemREAD(MemREAD), .memAddr(memAddr),
    .datatoMem(datatoMem), .datafromMem(data2), .rdValid(valid2), .ready(ready2),
    .addrErr(addrErr2)
  );

  // Common comparison helper; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a plain array for the memory, a count of post-reset
  // edges for the init sweep, and a time-stamped log of reads from which each
  // latency's output is picked.
  typedef struct {
    int          stamp;
    logic [63:0] data;
  } readRec_t;

  logic [63:0] modelMem [DEPTH];
  readRec_t    readLog[$];
  readRec_t    rec;
  int          edgeNum;
  int          initEdges;
  int          idx;
  logic        expReady;
  logic        expAddrErr;
  logic        expValid [1:2];
  logic [63:0] expData [1:2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (modelMem[i]) modelMem[i] = '0;
      readLog.delete();
      edgeNum    = 0;
      initEdges  = 0;
      expReady   = 1'b0;
      expAddrErr = 1'b0;
      for (int l = 1; l <= 2; l++) begin
        expValid[l] = 1'b0;
        expData[l]  = '0;
      end
    end else begin
      edgeNum++;
      if (!expReady) begin
        initEdges++;
        if (initEdges == DEPTH) expReady = 1'b1;
      end else begin
        idx = int'(memAddr) % DEPTH;
        if ((memWR || MemREAD) && (int'(memAddr) / DEPTH) != 0) expAddrErr = 1'b1;
        if (MemREAD) begin
          rec.stamp = edgeNum;
          rec.data  = modelMem[idx];
          readLog.push_back(rec);
        end
        if (memWR) modelMem[idx] = datatoMem;
      end
      for (int l = 1; l <= 2; l++) begin
        expValid[l] = 1'b0;
        foreach (readLog[k]) begin
          if (readLog[k].stamp == edgeNum - (l - 1)) begin
            expValid[l] = 1'b1;
            expData[l]  = readLog[k].data;
          end
        end
      end
      while (readLog.size() > 0 && readLog[0].stamp < edgeNum - 1) void'(readLog.pop_front());
    end
  end

  // Per-cycle compare of both DUTs against the model, shortly after each edge.
  always @(posedge clk) begin
    #2;
    checkOutput("ready1",   {63'd0, ready1},   {63'd0, expReady});
    checkOutput("ready2",   {63'd0, ready2},   {63'd0, expReady});
    checkOutput("addrErr1", {63'd0, addrErr1}, {63'd0, expAddrErr});
    checkOutput("addrErr2", {63'd0, addrErr2}, {63'd0, expAddrErr});
    checkOutput("rdValid1", {63'd0, valid1},   {63'd0, expValid[1]});
    checkOutput("rdValid2", {63'd0, valid2},   {63'd0, expValid[2]});
    checkOutput("data1",    data1,             expData[1]);
    checkOutput("data2",    data2,             expData[2]);
  end

  // Drive one cycle of inputs and return at the next falling edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                               input logic [63:0] data);
    memWR     = wr;
    MemREAD   = rd;
    memAddr   = addr;
    datatoMem = data;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'h0000, 64'd0);
  endtask

  // Random requests (including out-of-range) while waiting for ready; counts
  // cycles with ready low and any read pulses seen, bounded at 1000 cycles.
  task automatic waitReady(output int cycles, output int pulses);
    cycles = 0;
    pulses = 0;
    while (!(ready1 && ready2) && cycles < 1000) begin
      applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), {$urandom, $urandom});
      cycles++;
      if (valid1 || valid2) pulses++;
    end
  endtask

  task automatic randomTraffic(input int n, input bit allowUpper);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 255));
      if (allowUpper && $urandom_range(0, 9) == 0) a[15:8] = 8'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), a, {$urandom, $urandom});
    end
  endtask

  initial begin
    int cycles, pulses, cnt1, cnt2;
    logic [63:0] orData;
    logic [63:0] v1, v2, v3, x;

    v1 = 64'h0101_0101_0101_0101;
    v2 = 64'h0202_0202_0202_0202;
    v3 = 64'h0303_0303_0303_0303;
    x  = 64'hDEAD_BEEF_CAFE_F00D;

    @(negedge clk);
    idle();
    idle();
    checkOutput("resetReady",   {63'd0, ready1},   64'd0);
    checkOutput("resetValid",   {63'd0, valid2},   64'd0);
    checkOutput("resetData",    data1,             64'd0);
    checkOutput("resetAddrErr", {63'd0, addrErr2}, 64'd0);
    rst = 1'b0;

    waitReady(cycles, pulses);
    checkOutput("initCycles", 64'(cycles), 64'd256);
    checkOutput("initPulses", 64'(pulses), 64'd0);
    checkOutput("initAddrErr", {63'd0, addrErr1}, 64'd0);

    // Freshly cleared line reads back zero.
    applyStimulus(1'b0, 1'b1, 16'h005A, 64'd0);
    checkOutput("t1Valid1", {63'd0, valid1}, 64'd1);
    checkOutput("t1Valid2Early", {63'd0, valid2}, 64'd0);
    idle();
    checkOutput("t1Valid2", {63'd0, valid2}, 64'd1);
    checkOutput("t1Data2", data2, 64'd0);

    // Write then read next cycle.
    applyStimulus(1'b1, 1'b0, 16'h0010, 64'h1111_2222_3333_4444);
    applyStimulus(1'b0, 1'b1, 16'h0010, 64'd0);
    checkOutput("t2Data1", data1, 64'h1111_2222_3333_4444);
    idle();
    checkOutput("t2Data2", data2, 64'h1111_2222_3333_4444);

    // Same-cycle write and read return the old line.
    applyStimulus(1'b1, 1'b0, 16'h0020, 64'hA);
    applyStimulus(1'b1, 1'b1, 16'h0020, 64'hB);
    checkOutput("t3OldData", data1, 64'hA);
    applyStimulus(1'b0, 1'b1, 16'h0020, 64'd0);
    checkOutput("t3NewData", data1, 64'hB);
    idle();
    checkOutput("t3NewData2", data2, 64'hB);

    // Back-to-back reads.
    applyStimulus(1'b1, 1'b0, 16'h0001, v1);
    applyStimulus(1'b1, 1'b0, 16'h0002, v2);
    applyStimulus(1'b1, 1'b0, 16'h0003, v3);
    applyStimulus(1'b0, 1'b1, 16'h0001, 64'd0);
    checkOutput("t4Rd1", data1, v1);
    applyStimulus(1'b0, 1'b1, 16'h0002, 64'd0);
    checkOutput("t4Rd2", data1, v2);
    checkOutput("t4Rd1Lat2", data2, v1);
    applyStimulus(1'b0, 1'b1, 16'h0003, 64'd0);
    checkOutput("t4Rd3", data1, v3);
    checkOutput("t4Valid2", {63'd0, valid2}, 64'd1);
    idle();
    checkOutput("t4Rd3Lat2", data2, v3);
    checkOutput("t4Hold1", {valid1, data1[62:0]}, {1'b0, v3[62:0]});

    randomTraffic(600, 1'b0);
    checkOutput("t5AddrErrBefore", {63'd0, addrErr1}, 64'd0);

    // Out-of-range write aliases to line 5 and sets the sticky flag.
    applyStimulus(1'b1, 1'b0, 16'h0105, x);
    checkOutput("t5AddrErr", {63'd0, addrErr1}, 64'd1);
    applyStimulus(1'b0, 1'b1, 16'h0005, 64'd0);
    checkOutput("t5Alias", data1, x);
    randomTraffic(600, 1'b1);
    checkOutput("t5Sticky", {63'd0, addrErr2}, 64'd1);

    // Reset with a read in flight on the two-stage pipeline.
    applyStimulus(1'b0, 1'b1, 16'h0005, 64'd0);
    rst = 1'b1;
    pulses = 0;
    idle();
    if (valid1 || valid2) pulses++;
    idle();
    if (valid1 || valid2) pulses++;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), {$urandom, $urandom});
      if (valid1 || valid2) pulses++;
    end
    rst = 1'b1;
    idle();
    if (valid1 || valid2) pulses++;
    idle();
    if (valid1 || valid2) pulses++;
    rst = 1'b0;
    checkOutput("t6AddrErrCleared", {63'd0, addrErr1}, 64'd0);
    waitReady(cycles, cnt1);
    checkOutput("t6InitCycles", 64'(cycles), 64'd256);
    checkOutput("t6NoPulses", 64'(pulses + cnt1), 64'd0);

    // Every line must read back zero after the full sweep.
    cnt1 = 0;
    cnt2 = 0;
    orData = '0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) applyStimulus(1'b0, 1'b1, 16'(i), 64'd0);
      else idle();
      if (valid1) begin cnt1++; orData |= data1; end
      if (valid2) begin cnt2++; orData |= data2; end
    end
    checkOutput("t6ReadCount1", 64'(cnt1), 64'd256);
    checkOutput("t6ReadCount2", 64'(cnt2), 64'd256);
    checkOutput("t6AllZero", orData, 64'd0);

    randomTraffic(300, 1'b1);
    idle();
    idle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
